// File: rtl/xor_stream_decrypt_if.sv
// AXI4-Stream bundle used on both sides of the XOR stream decryptor.
// The master drives the beat and valid; the slave drives ready.
interface xor_stream_decrypt_if #(
  parameter int DW = 256,
  parameter int UW = 128
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/xor_stream_decrypt.sv
// Strips the 32-bit XOR key from an AXI4-Stream packet flow (WORD1 keeps its low 16 bits clear),
// with per-packet key/bypass latching, byte sanitising and a registered output backed by a one-entry skid.
module xor_stream_decrypt #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                    axis_aclk,
  input  logic                    axis_reset,
  xor_stream_decrypt_if.slave     s_axis,
  xor_stream_decrypt_if.master    m_axis,
  input  logic [31:0]             key,
  input  logic                    bypass,
  input  logic                    clear_counters,
  output logic [31:0]             pkt_count,
  output logic [31:0]             bypass_count
);

  localparam int DW  = C_S_AXIS_DATA_WIDTH;
  localparam int UW  = C_S_AXIS_TUSER_WIDTH;
  localparam int KW  = DW / 8;
  localparam int N   = DW / 32;
  localparam int MDW = C_M_AXIS_DATA_WIDTH;
  localparam int MUW = C_M_AXIS_TUSER_WIDTH;

  typedef enum logic [1:0] {WORD0, WORD1, PAYLOAD} state_t;

  state_t state, state_next;
  logic [31:0] key_r;
  logic        byp_r;
  logic        ready_r;
  logic        accept;
  logic [31:0] key_eff;
  logic        byp_eff;
  logic [DW-1:0] mask;
  logic [DW-1:0] beat_data;

  logic            out_valid;
  logic [MDW-1:0]  out_data;
  logic [MDW/8-1:0] out_keep;
  logic [MUW-1:0]  out_user;
  logic            out_last;
  logic            out_free;

  logic            skid_valid;
  logic [DW-1:0]   skid_data;
  logic [KW-1:0]   skid_keep;
  logic [UW-1:0]   skid_user;
  logic            skid_last;

  logic [31:0] pkt_cnt_r;
  logic [31:0] byp_cnt_r;

  assign accept   = s_axis.tvalid & ready_r;
  assign out_free = ~out_valid | m_axis.tready;

  // The WORD0 beat itself already uses the live key/bypass it is about to latch.
  assign key_eff = (state == WORD0) ? key    : key_r;
  assign byp_eff = (state == WORD0) ? bypass : byp_r;

  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        WORD0:   state_next = s_axis.tlast ? WORD0 : WORD1;
        WORD1:   state_next = s_axis.tlast ? WORD0 : PAYLOAD;
        PAYLOAD: state_next = s_axis.tlast ? WORD0 : PAYLOAD;
        default: state_next = WORD0;
      endcase
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state <= WORD0;
      key_r <= 32'h0;
      byp_r <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && state == WORD0) begin
        key_r <= key;
        byp_r <= bypass;
      end
    end
  end

  always_comb begin
    mask = '0;
    case (state)
      WORD1:   mask = {{(N-1){key_eff}}, key_eff[31:16], 16'h0000};
      PAYLOAD: mask = {N{key_eff}};
      default: mask = '0;
    endcase
    if (byp_eff) mask = '0;
    beat_data = s_axis.tdata ^ mask;
    for (int i = 0; i < KW; i++) begin
      if (!s_axis.tkeep[i]) beat_data[i*8 +: 8] = 8'h00;
    end
  end

  // Output register refills from the skid first so beat order is preserved.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_user   <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_keep  <= '0;
      skid_user  <= '0;
      skid_last  <= 1'b0;
      ready_r    <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          out_keep   <= skid_keep;
          out_user   <= skid_user;
          out_last   <= skid_last;
          skid_valid <= 1'b0;
        end else if (accept) begin
          out_valid <= 1'b1;
          out_data  <= beat_data;
          out_keep  <= s_axis.tkeep;
          out_user  <= s_axis.tuser;
          out_last  <= s_axis.tlast;
        end else begin
          out_valid <= 1'b0;
        end
        ready_r <= 1'b1;
      end else begin
        if (accept) begin
          skid_valid <= 1'b1;
          skid_data  <= beat_data;
          skid_keep  <= s_axis.tkeep;
          skid_user  <= s_axis.tuser;
          skid_last  <= s_axis.tlast;
        end
        ready_r <= ~(skid_valid | accept);
      end
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      pkt_cnt_r <= 32'h0;
      byp_cnt_r <= 32'h0;
    end else if (clear_counters) begin
      pkt_cnt_r <= 32'h0;
      byp_cnt_r <= 32'h0;
    end else if (accept && s_axis.tlast) begin
      if (byp_eff) byp_cnt_r <= byp_cnt_r + 32'h1;
      else         pkt_cnt_r <= pkt_cnt_r + 32'h1;
    end
  end

  assign s_axis.tready = ready_r;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tkeep  = out_keep;
  assign m_axis.tuser  = out_user;
  assign m_axis.tlast  = out_last;
  assign pkt_count     = pkt_cnt_r;
  assign bypass_count  = byp_cnt_r;

endmodule

// File: tb/tb_xor_stream_decrypt.sv
// Self-checking bench for xor_stream_decrypt: a packet-level model predicts every output beat,
// counter value and ready level, and directed packets pin the model with literal expectations.
module tb_xor_stream_decrypt;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;
  localparam int N  = DW / 32;
  localparam logic [31:0]   K       = 32'hA5C3_1E7F;
  localparam logic [DW-1:0] W1MASK  = {{7{32'hA5C3_1E7F}}, 32'hA5C3_0000};
  localparam logic [DW-1:0] PAYMASK = {8{32'hA5C3_1E7F}};
  localparam logic [KW-1:0] ALLKEEP = {KW{1'b1}};

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [31:0] key;
  logic        bypass;
  logic        clear_counters;
  logic [31:0] pkt_count;
  logic [31:0] bypass_count;

  xor_stream_decrypt_if #(.DW(DW), .UW(UW)) s_if ();
  xor_stream_decrypt_if #(.DW(DW), .UW(UW)) m_if ();

  xor_stream_decrypt #(
    .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
    .C_M_AXIS_TUSER_WIDTH(UW), .C_S_AXIS_TUSER_WIDTH(UW)
  ) dut (
    .axis_aclk(clk), .axis_reset(rst),
    .s_axis(s_if.slave), .m_axis(m_if.master),
    .key(key), .bypass(bypass), .clear_counters(clear_counters),
    .pkt_count(pkt_count), .bypass_count(bypass_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_mode = 0;

  beat_t         q[$];
  logic [DW-1:0] out_log[$];
  int            m_idx = 0;
  logic [31:0]   m_key = 0;
  logic          m_byp = 0;
  logic [31:0]   exp_pc = 0;
  logic [31:0]   exp_bc = 0;
  int            since = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Position-in-packet rule: first beat clear, second beat keyed except its low 16 bits, rest keyed.
  function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] d, input logic [KW-1:0] kp,
                                               input int idx, input logic [31:0] k, input logic b);
    logic [DW-1:0] m;
    logic [DW-1:0] r;
    for (int w = 0; w < N; w++) m[w*32 +: 32] = k;
    if (idx == 0 || b) m = '0;
    else if (idx == 1) m[15:0] = 16'h0;
    r = d ^ m;
    for (int i = 0; i < KW; i++) if (!kp[i]) r[i*8 +: 8] = 8'h00;
    return r;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      q.delete();
      m_idx  = 0;
      exp_pc = 0;
      exp_bc = 0;
      since  = 0;
    end else begin
      if (since < 2) since++;
      checkOutput("pkt_count", {224'h0, pkt_count}, {224'h0, exp_pc});
      checkOutput("bypass_count", {224'h0, bypass_count}, {224'h0, exp_bc});
      if (since >= 2)
        checkOutput("s_tready", {255'h0, s_if.tready}, {255'h0, (q.size() < 2)});
      if (m_if.tvalid && m_if.tready) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_beat", 256'h1, 256'h0);
        end else begin
          e = q.pop_front();
          checkOutput("m_tdata", m_if.tdata, e.d);
          checkOutput("m_side", {95'h0, m_if.tkeep, m_if.tuser, m_if.tlast},
                                {95'h0, e.k, e.u, e.l});
        end
        out_log.push_back(m_if.tdata);
      end
      if (s_if.tvalid && s_if.tready) begin
        if (m_idx == 0) begin
          m_key = key;
          m_byp = bypass;
        end
        e.d = model_beat(s_if.tdata, s_if.tkeep, m_idx, m_key, m_byp);
        e.k = s_if.tkeep;
        e.u = s_if.tuser;
        e.l = s_if.tlast;
        q.push_back(e);
        if (s_if.tlast) begin
          if (m_byp) exp_bc = exp_bc + 32'h1;
          else       exp_pc = exp_pc + 32'h1;
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (clear_counters) begin
        exp_pc = 0;
        exp_bc = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] d, input logic [KW-1:0] kp, input logic lst,
                               input logic [31:0] k, input logic b);
    bit got;
    s_if.tdata  = d;
    s_if.tkeep  = kp;
    s_if.tuser  = d[UW-1:0] ^ 128'h5A5A_0F0F_3C3C_9696_1234_5678_9ABC_DEF0;
    s_if.tlast  = lst;
    s_if.tvalid = 1'b1;
    key         = k;
    bypass      = b;
    got = 0;
    for (int w = 0; w < 500; w++) begin
      @(negedge clk);
      if (s_if.tready) begin
        got = 1;
        break;
      end
    end
    checkOutput("accept_timeout", {255'h0, got}, 256'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    s_if.tvalid = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    bit done;
    s_if.tvalid = 1'b0;
    done = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        done = 1;
        break;
      end
    end
    checkOutput("drain_timeout", {255'h0, done}, 256'h1);
    idle(1);
  endtask

  task automatic pulse_clear();
    clear_counters = 1'b1;
    idle(1);
    clear_counters = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    idle(2);
    @(negedge clk);
    checkOutput("rst_m_tvalid", {255'h0, m_if.tvalid}, 256'h0);
    checkOutput("rst_s_tready", {255'h0, s_if.tready}, 256'h0);
    checkOutput("rst_m_tdata", m_if.tdata, 256'h0);
    checkOutput("rst_side", {95'h0, m_if.tkeep, m_if.tuser, m_if.tlast}, 256'h0);
    checkOutput("rst_counts", {192'h0, pkt_count, bypass_count}, 256'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
  endtask

  logic [DW-1:0] p[4];
  logic [DW-1:0] rd;
  logic [KW-1:0] rk;

  initial begin
    rst = 1'b1;
    key = 32'h0;
    bypass = 1'b0;
    clear_counters = 1'b0;
    s_if.tdata = '0;
    s_if.tkeep = '0;
    s_if.tuser = '0;
    s_if.tlast = 1'b0;
    s_if.tvalid = 1'b0;
    do_reset();
    checkOutput("post_rst_ready", {255'h0, s_if.tready}, 256'h1);

    // Round trip of a 4-beat packet encrypted with K.
    p[0] = {4{64'h0011_2233_4455_6677}};
    p[1] = {4{64'h8899_AABB_CCDD_EEFF}};
    p[2] = {4{64'h0123_4567_89AB_CDEF}};
    p[3] = {4{64'hFEDC_BA98_7654_3210}};
    out_log.delete();
    applyStimulus(p[0],           ALLKEEP, 1'b0, K, 1'b0);
    applyStimulus(p[1] ^ W1MASK,  ALLKEEP, 1'b0, K, 1'b0);
    applyStimulus(p[2] ^ PAYMASK, ALLKEEP, 1'b0, K, 1'b0);
    applyStimulus(p[3] ^ PAYMASK, ALLKEEP, 1'b1, K, 1'b0);
    drain();
    for (int i = 0; i < 4; i++) checkOutput("roundtrip", out_log[i], p[i]);
    checkOutput("roundtrip_pkt", {224'h0, pkt_count}, 256'h1);

    // Key change mid-packet only affects the following packet.
    out_log.delete();
    applyStimulus(256'h0, ALLKEEP, 1'b0, K,     1'b0);
    applyStimulus(256'h0, ALLKEEP, 1'b0, 32'h0, 1'b0);
    applyStimulus(256'h0, ALLKEEP, 1'b1, 32'h0, 1'b0);
    applyStimulus(256'h0, ALLKEEP, 1'b0, 32'h0, 1'b0);
    applyStimulus(256'h0, ALLKEEP, 1'b0, 32'h0, 1'b0);
    applyStimulus(256'h0, ALLKEEP, 1'b1, K,     1'b0);
    drain();
    checkOutput("keychg_b0", out_log[0], 256'h0);
    checkOutput("keychg_b1", out_log[1], W1MASK);
    checkOutput("keychg_b2", out_log[2], PAYMASK);
    checkOutput("keychg_next_b1", out_log[4], 256'h0);
    checkOutput("keychg_next_b2", out_log[5], 256'h0);

    // Bypass latched on the first beat only.
    pulse_clear();
    out_log.delete();
    applyStimulus({8{32'hDEAD_BEEF}}, ALLKEEP, 1'b0, K, 1'b1);
    applyStimulus({8{32'hDEAD_BEEF}}, ALLKEEP, 1'b0, K, 1'b0);
    applyStimulus({8{32'hDEAD_BEEF}}, ALLKEEP, 1'b1, K, 1'b0);
    drain();
    for (int i = 0; i < 3; i++) checkOutput("bypass_data", out_log[i], {8{32'hDEAD_BEEF}});
    checkOutput("bypass_counts", {192'h0, pkt_count, bypass_count}, {192'h0, 32'h0, 32'h1});

    // Single-beat packet with partial tkeep, then a 2-beat packet.
    out_log.delete();
    applyStimulus({8{32'h1234_5678}}, 32'h0000_FFFF, 1'b1, K, 1'b0);
    applyStimulus(256'h0, ALLKEEP, 1'b0, K, 1'b0);
    applyStimulus(256'h0, ALLKEEP, 1'b1, K, 1'b0);
    drain();
    checkOutput("keep_sanitise", out_log[0], {128'h0, {4{32'h1234_5678}}});
    checkOutput("after_single_w1", out_log[2], W1MASK);
    checkOutput("after_single_pkt", {224'h0, pkt_count}, 256'h2);

    // 100 beats under random output backpressure.
    out_log.delete();
    rand_mode = 1;
    begin
      int remaining;
      int len;
      logic [31:0] pk;
      logic        pb;
      remaining = 100;
      while (remaining > 0) begin
        len = $urandom_range(1, 6);
        if (len > remaining) len = remaining;
        pk = $urandom;
        pb = ($urandom_range(0, 3) == 0);
        for (int j = 0; j < len; j++) begin
          for (int w = 0; w < N; w++) rd[w*32 +: 32] = $urandom;
          rk = ($urandom_range(0, 1) == 1) ? ALLKEEP : KW'($urandom);
          applyStimulus(rd, rk, (j == len - 1), (j == 0) ? pk : $urandom,
                        (j == 0) ? pb : ($urandom_range(0, 1) == 1));
        end
        remaining -= len;
      end
    end
    rand_mode = 0;
    drain();
    checkOutput("random_beats", 256'(out_log.size()), 256'd100);

    // Counter wrap and clear-wins on a tlast accept.
    idle(1);
    #1;
    force dut.pkt_cnt_r = 32'hFFFF_FFFF;
    exp_pc = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt_r;
    idle(2);
    checkOutput("preset_pkt", {224'h0, pkt_count}, {224'h0, 32'hFFFF_FFFF});
    applyStimulus(256'h1, ALLKEEP, 1'b1, K, 1'b0);
    drain();
    checkOutput("wrap_pkt", {224'h0, pkt_count}, 256'h0);
    applyStimulus(256'h2, ALLKEEP, 1'b1, K, 1'b0);
    drain();
    checkOutput("count_one", {224'h0, pkt_count}, 256'h1);
    applyStimulus(256'h3, ALLKEEP, 1'b0, K, 1'b0);
    clear_counters = 1'b1;
    applyStimulus(256'h4, ALLKEEP, 1'b1, K, 1'b0);
    clear_counters = 1'b0;
    drain();
    checkOutput("clear_wins", {224'h0, pkt_count}, 256'h0);

    // Reset in the middle of a packet: the next beat is a first beat again.
    applyStimulus(256'h0, ALLKEEP, 1'b0, K, 1'b0);
    applyStimulus(256'h0, ALLKEEP, 1'b0, K, 1'b0);
    drain();
    do_reset();
    out_log.delete();
    applyStimulus(256'h0, ALLKEEP, 1'b0, K, 1'b0);
    applyStimulus(256'h0, ALLKEEP, 1'b1, K, 1'b0);
    drain();
    checkOutput("midrst_b0", out_log[0], 256'h0);
    checkOutput("midrst_b1", out_log[1], W1MASK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
